// File: rtl/uart_tx_top.sv
// uart_tx_top: 16550-style UART transmitter.
// Pops one character from a first-word-fall-through TX FIFO and serialises it on tx:
// start bit, 5-8 data bits (LSB first), optional parity, then 1/1.5/2 stop bits.
// Each bit lasts OVERSAMPLE baud_pulse ticks; all state advances only on baud_pulse clocks.
// Optional feature macro: UART_TX_BREAK_EN (set_break forces tx low over the FSM output).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   baud_pulse        one-clk tick, OVERSAMPLE per bit time
//   thre, din         FIFO empty flag and FIFO head data
//   wls, stb          word length (N = wls+5) and stop-bit select
//   pen, eps,
//   sticky_parity     parity enable / even select / sticky select
//   set_break         break control (used only with UART_TX_BREAK_EN)
//   pop               one-clk pulse when din is consumed
//   sreg_empty        1 when no frame is in progress
//   tx                serial line, idle high
module uart_tx_top #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       thre,
  input  logic [7:0] din,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       set_break,
  output logic       pop,
  output logic       sreg_empty,
  output logic       tx
);

  // Tick counter must reach 2*OVERSAMPLE-1 (two stop bits).
  localparam int unsigned TICK_W = $clog2(2 * OVERSAMPLE);

  localparam logic [TICK_W-1:0] LAST_BIT_TICK  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] LAST_STOP1     = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] LAST_STOP1P5   = TICK_W'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_STOP2     = TICK_W'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            state_q, state_n;
  logic [TICK_W-1:0] tick_q, tick_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        shift_q, shift_n;
  logic [1:0]        wls_q, wls_n;
  logic              stb_q, stb_n;
  logic              pen_q, pen_n;
  logic              parity_q, parity_n;
  logic              tx_q, tx_n;
  logic              pop_q, pop_n;
  logic              empty_q, empty_n;

  // Parity of the incoming character, computed at load over the N data bits only.
  logic [7:0] load_mask_c;
  logic [7:0] load_data_c;
  logic       load_parity_c;

  always_comb begin
    load_mask_c = 8'(8'hFF >> (2'd3 - wls));
    load_data_c = din & load_mask_c;
    case ({sticky_parity, eps})
      2'b00:   load_parity_c = ~^load_data_c;
      2'b01:   load_parity_c = ^load_data_c;
      2'b10:   load_parity_c = 1'b1;
      default: load_parity_c = 1'b0;
    endcase
  end

  // Frame-shape decode from the latched configuration.
  logic [2:0]        last_bit_c;
  logic [TICK_W-1:0] last_stop_c;

  always_comb begin
    last_bit_c = 3'({1'b0, wls_q}) + 3'd4;
    if (!stb_q)              last_stop_c = LAST_STOP1;
    else if (wls_q == 2'b00) last_stop_c = LAST_STOP1P5;
    else                     last_stop_c = LAST_STOP2;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wls_q    <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      pop_q    <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_n;
      tick_q   <= tick_n;
      bit_q    <= bit_n;
      shift_q  <= shift_n;
      wls_q    <= wls_n;
      stb_q    <= stb_n;
      pen_q    <= pen_n;
      parity_q <= parity_n;
      tx_q     <= tx_n;
      pop_q    <= pop_n;
      empty_q  <= empty_n;
    end
  end

  // Next-state and next-output logic; everything holds except on baud_pulse clocks.
  always_comb begin
    state_n  = state_q;
    tick_n   = tick_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    wls_n    = wls_q;
    stb_n    = stb_q;
    pen_n    = pen_q;
    parity_n = parity_q;
    tx_n     = tx_q;
    pop_n    = 1'b0;
    empty_n  = empty_q;

    if (baud_pulse) begin
      case (state_q)
        ST_IDLE: begin
          tx_n    = 1'b1;
          empty_n = 1'b1;
          if (!thre) begin
            shift_n  = din;
            wls_n    = wls;
            stb_n    = stb;
            pen_n    = pen;
            parity_n = load_parity_c;
            pop_n    = 1'b1;
            empty_n  = 1'b0;
            tx_n     = 1'b0;
            tick_n   = '0;
            bit_n    = '0;
            state_n  = ST_START;
          end
        end

        ST_START: begin
          if (tick_q == LAST_BIT_TICK) begin
            tick_n  = '0;
            tx_n    = shift_q[0];
            state_n = ST_DATA;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end

        ST_DATA: begin
          if (tick_q == LAST_BIT_TICK) begin
            tick_n = '0;
            if (bit_q == last_bit_c) begin
              if (pen_q) begin
                tx_n    = parity_q;
                state_n = ST_PARITY;
              end else begin
                tx_n    = 1'b1;
                state_n = ST_STOP;
              end
            end else begin
              bit_n   = bit_q + 3'd1;
              shift_n = {1'b0, shift_q[7:1]};
              tx_n    = shift_q[1];
            end
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end

        ST_PARITY: begin
          if (tick_q == LAST_BIT_TICK) begin
            tick_n  = '0;
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end

        ST_STOP: begin
          if (tick_q == last_stop_c) begin
            tick_n  = '0;
            tx_n    = 1'b1;
            empty_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end

        default: begin
          tx_n    = 1'b1;
          empty_n = 1'b1;
          tick_n  = '0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign pop        = pop_q;
  assign sreg_empty = empty_q;

`ifdef UART_TX_BREAK_EN
  // Break overrides the line without disturbing the frame in progress.
  assign tx = tx_q & ~set_break;
`else
  logic unused_set_break;
  assign unused_set_break = set_break;
  assign tx = tx_q;
`endif

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: randomized scoreboard bench for uart_tx_top.
// A FIFO model feeds the DUT; each enqueued character pushes its expected frame into a
// scoreboard queue, and a monitor pops and checks the tx waveform tick by tick.
module tb_uart_tx_top;

  localparam int unsigned OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sticky;
  } frame_t;

  logic       clk;
  logic       rst;
  logic       baud_pulse;
  logic       thre;
  logic [7:0] din;
  logic [1:0] wls;
  logic       stb;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic       set_break;
  logic       pop;
  logic       sreg_empty;
  logic       tx;

  frame_t fifo[$];
  frame_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  bit mon_en   = 1'b0;
  bit bp_dense = 1'b0;
  bit brk_en   = 1'b0;
  bit in_frame = 1'b0;
  bit idle_err = 1'b0;
  logic idle_tx, idle_se;

  uart_tx_top #(.OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .thre          (thre),
    .din           (din),
    .wls           (wls),
    .stb           (stb),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .set_break     (set_break),
    .pop           (pop),
    .sreg_empty    (sreg_empty),
    .tx            (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame shape from the protocol rules.
  function automatic int n_bits(input frame_t f);
    return int'(f.wls) + 5;
  endfunction

  function automatic int frame_len(input frame_t f);
    int stop;
    if (!f.stb)            stop = OS;
    else if (f.wls == 2'b00) stop = (3 * OS) / 2;
    else                   stop = 2 * OS;
    return (1 + n_bits(f) + int'(f.pen)) * OS + stop;
  endfunction

  function automatic logic parity_of(input frame_t f);
    int ones = 0;
    for (int i = 0; i < n_bits(f); i++) ones += int'(f.d[i]);
    if (f.sticky) return ~f.eps;
    if (f.eps)    return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  // Line level during the k-th tick interval after the load tick.
  function automatic logic level_at(input frame_t f, input int k);
    int idx;
    if (k < OS) return 1'b0;
    idx = (k - OS) / OS;
    if (idx < n_bits(f)) return f.d[idx];
    if (f.pen && idx == n_bits(f)) return parity_of(f);
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic enq(input frame_t f, input bit track);
    fifo.push_back(f);
    if (track) exp_q.push_back(f);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    f.d      = 8'($urandom);
    f.wls    = 2'($urandom);
    f.stb    = 1'($urandom);
    f.pen    = 1'($urandom);
    f.eps    = 1'($urandom);
    f.sticky = 1'($urandom_range(0, 3) == 0);
    return f;
  endfunction

  // FIFO / baud driver: inputs change on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (pop === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
      baud_pulse = bp_dense ? 1'b1 : ($urandom_range(0, 1) == 0);
      if (fifo.size() > 0) begin
        thre          = 1'b0;
        din           = fifo[0].d;
        wls           = fifo[0].wls;
        stb           = fifo[0].stb;
        pen           = fifo[0].pen;
        eps           = fifo[0].eps;
        sticky_parity = fifo[0].sticky;
      end else begin
        thre          = 1'b1;
        din           = 8'($urandom);
        wls           = 2'($urandom);
        stb           = 1'($urandom);
        pen           = 1'($urandom);
        eps           = 1'($urandom);
        sticky_parity = 1'($urandom);
      end
      if (!brk_en) set_break = 1'b0;
      else if ($urandom_range(0, 39) == 0) set_break = ~set_break;
    end
  end

  // Monitor: pops the expected frame on each pop and checks tx every clock.
  initial begin
    bit     expect_load = 1'b0;
    bit     frame_err   = 1'b0;
    frame_t cur;
    int     k = 0;
    int     len = 0;
    int     err_k = 0;
    logic   err_tx, err_se, err_req;
    logic   bp, exp_tx;
    cur = '0;
    forever begin
      @(posedge clk);
      bp = baud_pulse;
      #1;
      if (!mon_en) begin
        in_frame    = 1'b0;
        expect_load = 1'b0;
        idle_err    = 1'b0;
      end else begin
        if (bp && expect_load) begin
          checks++;
          if (pop !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: pop=%b one tick after stop, required 1", pop);
          end
          expect_load = 1'b0;
        end
        if (pop === 1'b1) begin
          checks++;
          if (in_frame || !bp || exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected: pop=1 in_frame=%b bp=%b pending=%0d, required no pop",
                     in_frame, bp, exp_q.size());
          end else begin
            checks++;
            if (idle_err) begin
              failures++;
              $display("FAIL idle_line: tx=%b sreg_empty=%b while idle, required 1/1",
                       idle_tx, idle_se);
            end
            idle_err  = 1'b0;
            cur       = exp_q.pop_front();
            len       = frame_len(cur);
            k         = 0;
            frame_err = 1'b0;
            in_frame  = 1'b1;
          end
        end else if (in_frame && bp) begin
          k++;
          if (k == len) begin
            checks++;
            if (frame_err) begin
              failures++;
              $display("FAIL frame_wave d=%h wls=%0d pen=%b stb=%b: tick %0d tx=%b sreg_empty=%b, required tx=%b sreg_empty=0",
                       cur.d, cur.wls, cur.pen, cur.stb, err_k, err_tx, err_se, err_req);
            end
            in_frame    = 1'b0;
            expect_load = fifo.size() > 0;
          end
        end
        exp_tx = in_frame ? level_at(cur, k) : 1'b1;
`ifdef UART_TX_BREAK_EN
        exp_tx = exp_tx & ~set_break;
`endif
        if (in_frame) begin
          if ((tx !== exp_tx || sreg_empty !== 1'b0) && !frame_err) begin
            frame_err = 1'b1;
            err_k     = k;
            err_tx    = tx;
            err_se    = sreg_empty;
            err_req   = exp_tx;
          end
        end else if ((tx !== exp_tx || sreg_empty !== 1'b1) && !idle_err) begin
          idle_err = 1'b1;
          idle_tx  = tx;
          idle_se  = sreg_empty;
        end
      end
    end
  end

  task automatic wait_idle(input int max_clks);
    int n = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0 || in_frame) && n < max_clks) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (n >= max_clks) begin
      failures++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d clks, required 0",
               exp_q.size(), max_clks);
    end
  endtask

  task automatic push_at_edge(input frame_t f, input bit track);
    @(posedge clk);
    #3;
    enq(f, track);
  endtask

  initial begin
    frame_t f;
    int     n;
    bit     bad;
    rst = 1'b1; baud_pulse = 1'b0; thre = 1'b1; din = '0; wls = '0;
    stb = 1'b0; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; set_break = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_sreg_empty", 32'(sreg_empty), 32'd1);
    chk("reset_pop", 32'(pop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // 8N1 0xA5
    push_at_edge(frame_t'{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_idle(4000);
    // 7E2 0xC3: bit 7 never sent
    push_at_edge(frame_t'{8'hC3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b1);
    wait_idle(4000);
    // 5-bit 1.5 stop, sticky parity 1
    push_at_edge(frame_t'{8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1}, 1'b1);
    wait_idle(4000);
    // 5O1.5 odd parity
    push_at_edge(frame_t'{8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b1);
    wait_idle(4000);

    // Back-to-back at full baud rate
    bp_dense = 1'b1;
    @(posedge clk);
    #3;
    enq(frame_t'{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    enq(frame_t'{8'hAA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_idle(2000);
    bp_dense = 1'b0;

    // Empty FIFO: line must stay idle
    repeat (200) @(posedge clk);

    // Random traffic with optional break activity
    brk_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 250)) @(posedge clk);
      bp_dense = ($urandom_range(0, 3) == 0);
      push_at_edge(rand_frame(), 1'b1);
      if ($urandom_range(0, 2) == 0) enq(rand_frame(), 1'b1);
    end
    wait_idle(20000);
    brk_en = 1'b0;
    bp_dense = 1'b0;
    repeat (3) @(posedge clk);

    // Reset mid-frame at tick 70
    mon_en = 1'b0;
    push_at_edge(frame_t'{8'h3C, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
    n = 0;
    while (pop !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reset_test_pop_seen", 32'(pop), 32'd1);
    n = 0;
    while (n < 70) begin
      @(posedge clk);
      if (baud_pulse) n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_tx", 32'(tx), 32'd1);
    chk("midreset_sreg_empty", 32'(sreg_empty), 32'd1);
    chk("midreset_pop", 32'(pop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (pop !== 1'b0 || tx !== 1'b1 || sreg_empty !== 1'b1) bad = 1'b1;
    end
    chk("post_reset_no_repop", 32'(bad), 32'd0);

    // Traffic resumes normally after reset
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f = rand_frame();
      push_at_edge(f, 1'b1);
    end
    wait_idle(8000);

    repeat (50) @(posedge clk);
    #2;
    checks++;
    if (idle_err) begin
      failures++;
      $display("FAIL final_idle: tx=%b sreg_empty=%b while idle, required 1/1", idle_tx, idle_se);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
